// File: rtl/uart_cmd_parser_pkg.sv
// Shared encodings for the UART command parser slice.
//   - Parser FSM state codes (HUNT, ADDR, LEN, DATA, CSUM, EMIT)
//   - Receiver acknowledge FSM state codes (WAIT, HOLD, DROP)
//   - Response bytes (ACK / NAK) and the default frame sync marker
package uart_cmd_parser_pkg;

  localparam logic [2:0] ST_HUNT = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_LEN  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CSUM = 3'd4;
  localparam logic [2:0] ST_EMIT = 3'd5;

  localparam logic [1:0] ACK_WAIT = 2'd0;
  localparam logic [1:0] ACK_HOLD = 2'd1;
  localparam logic [1:0] ACK_DROP = 2'd2;

  localparam logic [7:0] ACK_BYTE          = 8'h06;
  localparam logic [7:0] NAK_BYTE          = 8'h15;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_byte_ack.sv
// Four-phase acknowledge toward the UART byte receiver.
// Captures one byte per valid assertion and presents it to the parser with a
// one-cycle strobe. Capture is suppressed while i_hold is high, leaving the
// byte pending in the receiver.
// Ports:
//   i_uart_clk, i_rst_n : clock, asynchronous active-low reset
//   i_rx_byte, i_rx_valid : receiver byte and level valid
//   i_hold              : parser busy emitting, do not accept
//   o_rx_ready          : acknowledge, high for exactly one cycle per byte
//   o_byte_stb, o_byte  : captured byte and its one-cycle strobe
module uart_byte_ack
  import uart_cmd_parser_pkg::*;
(
  input  logic       i_uart_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_byte,
  input  logic       i_rx_valid,
  input  logic       i_hold,
  output logic       o_rx_ready,
  output logic       o_byte_stb,
  output logic [7:0] o_byte
);

  logic [1:0] ack_state;
  logic [7:0] rx_byte_p0;
  logic       take;

  assign take = (ack_state == ACK_WAIT) && i_rx_valid && !i_hold;

  always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_state <= ACK_WAIT;
    end else begin
      case (ack_state)
        ACK_WAIT: if (take) ack_state <= ACK_HOLD;
        ACK_HOLD: ack_state <= ACK_DROP;
        ACK_DROP: if (!i_rx_valid) ack_state <= ACK_WAIT;
        default:  ack_state <= ACK_WAIT;
      endcase
    end
  end

  // capture stage -> byte presented during HOLD
  always_ff @(posedge i_uart_clk) begin
    if (take) rx_byte_p0 <= i_rx_byte;
  end

  // Ready and strobe share the HOLD cycle so the parser sees each byte once.
  assign o_rx_ready = (ack_state == ACK_HOLD);
  assign o_byte_stb = (ack_state == ACK_HOLD);
  assign o_byte     = rx_byte_p0;

endmodule

// File: rtl/uart_cmd_parser.sv
// Framed write-command parser behind the UART byte receiver.
// Frame: SYNC, ADDR, LEN (1..MAX_PAYLOAD), LEN payload bytes, XOR checksum
// over ADDR..payload. The payload is buffered and emitted as addr/data write
// beats only after the checksum matches.
// Optional feature macro CMD_PARSER_RESP_EN adds an ACK/NAK response request
// toward a UART transmitter (o_tx_byte, o_tx_start, i_tx_busy).
// Ports:
//   i_uart_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_rx_byte, i_rx_valid, o_rx_ready : receiver four-phase handshake
//   o_wr_en, o_wr_addr, o_wr_data, i_wr_ready : write beat output
//   o_frame_ok, o_frame_err        : one-cycle per-frame status pulses
//   o_busy                         : parser not in HUNT
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int         MAX_PAYLOAD    = 16,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 2780
) (
  input  logic       i_uart_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_byte,
  input  logic       i_rx_valid,
  output logic       o_rx_ready,
  output logic       o_wr_en,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  input  logic       i_wr_ready,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic       o_busy
`ifdef CMD_PARSER_RESP_EN
  ,
  output logic [7:0] o_tx_byte,
  output logic       o_tx_start,
  input  logic       i_tx_busy
`endif
);

  localparam int IDX_W = $clog2(MAX_PAYLOAD + 1);
  localparam int PTR_W = $clog2(MAX_PAYLOAD);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [7:0]       MAX_LEN  = 8'(MAX_PAYLOAD);
  // Registered error lands on the cycle the counter reaches TIMEOUT_CYCLES-1.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);

  logic [2:0]       p_state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_inc;
  logic [IDX_W-1:0] len_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic [7:0]       base_addr;
  logic [7:0]       csum;
  logic [7:0]       pld_buf [MAX_PAYLOAD];
  logic             frame_ok;
  logic             frame_err;

  logic             byte_stb;
  logic [7:0]       rx_byte;
  logic             emit;
  logic             in_frame;
  logic             last_beat;
  logic             len_ok;
  logic             tmo_hit;

  uart_byte_ack u_ack (
    .i_uart_clk (i_uart_clk),
    .i_rst_n    (i_rst_n),
    .i_rx_byte  (i_rx_byte),
    .i_rx_valid (i_rx_valid),
    .i_hold     (emit),
    .o_rx_ready (o_rx_ready),
    .o_byte_stb (byte_stb),
    .o_byte     (rx_byte)
  );

  assign emit      = (p_state == ST_EMIT);
  assign in_frame  = (p_state == ST_ADDR) || (p_state == ST_LEN) ||
                     (p_state == ST_DATA) || (p_state == ST_CSUM);
  assign idx_inc   = idx + IDX_W'(1);
  assign last_beat = (idx_inc == len_q);
  assign len_ok    = (rx_byte != 8'd0) && (rx_byte <= MAX_LEN);
  assign tmo_hit   = in_frame && !byte_stb && (tmo_cnt == TMO_LAST);

  // parse stage: control state
  always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p_state   <= ST_HUNT;
      idx       <= '0;
      tmo_cnt   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      if (byte_stb || !in_frame) tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + TMO_W'(1);

      case (p_state)
        ST_HUNT: if (byte_stb && rx_byte == SYNC_BYTE) p_state <= ST_ADDR;
        ST_ADDR: if (byte_stb) p_state <= ST_LEN;
        ST_LEN: begin
          if (byte_stb) begin
            if (len_ok) begin
              idx     <= '0;
              p_state <= ST_DATA;
            end else begin
              frame_err <= 1'b1;
              p_state   <= ST_HUNT;
            end
          end
        end
        ST_DATA: begin
          if (byte_stb) begin
            idx <= idx_inc;
            if (last_beat) p_state <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (byte_stb) begin
            if (rx_byte == csum) begin
              idx     <= '0;
              p_state <= ST_EMIT;
            end else begin
              frame_err <= 1'b1;
              p_state   <= ST_HUNT;
            end
          end
        end
        ST_EMIT: begin
          if (i_wr_ready) begin
            if (last_beat) begin
              frame_ok <= 1'b1;
              p_state  <= ST_HUNT;
            end else begin
              idx <= idx_inc;
            end
          end
        end
        default: p_state <= ST_HUNT;
      endcase

      if (tmo_hit) begin
        frame_err <= 1'b1;
        p_state   <= ST_HUNT;
      end
    end
  end

  // parse stage: frame data (address, length, checksum, payload)
  always_ff @(posedge i_uart_clk) begin
    if (byte_stb) begin
      case (p_state)
        ST_ADDR: begin
          base_addr <= rx_byte;
          csum      <= rx_byte;
        end
        ST_LEN: begin
          len_q <= rx_byte[IDX_W-1:0];
          csum  <= csum ^ rx_byte;
        end
        ST_DATA: begin
          pld_buf[idx[PTR_W-1:0]] <= rx_byte;
          csum                    <= csum ^ rx_byte;
        end
        default: ;
      endcase
    end
  end

  // emit stage
  assign o_wr_en     = emit;
  assign o_wr_addr   = emit ? (base_addr + 8'(idx)) : 8'd0;
  assign o_wr_data   = emit ? pld_buf[idx[PTR_W-1:0]] : 8'd0;
  assign o_frame_ok  = frame_ok;
  assign o_frame_err = frame_err;
  assign o_busy      = (p_state != ST_HUNT);

`ifdef CMD_PARSER_RESP_EN
  logic resp_pend;
  logic resp_nak;
  logic tx_start;

  // A newer status overwrites a pending one; sending waits for an idle tx.
  always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      resp_pend <= 1'b0;
      tx_start  <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (frame_ok || frame_err) begin
        resp_pend <= 1'b1;
      end else if (resp_pend && !i_tx_busy) begin
        tx_start  <= 1'b1;
        resp_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_uart_clk) begin
    if (frame_ok || frame_err) resp_nak <= frame_err;
  end

  assign o_tx_start = tx_start;
  assign o_tx_byte  = tx_start ? (resp_nak ? NAK_BYTE : ACK_BYTE) : 8'd0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: receiver handshake model, write-beat
// recorder, and hand-computed expectations for each frame scenario.
module tb_uart_cmd_parser;

  localparam int TMO = 2780;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ready;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       frame_ok;
  logic       frame_err;
  logic       busy;
`ifdef CMD_PARSER_RESP_EN
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       tx_busy = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_cmd_parser dut (
    .i_uart_clk  (clk),
    .i_rst_n     (rst_n),
    .i_rx_byte   (rx_byte),
    .i_rx_valid  (rx_valid),
    .o_rx_ready  (rx_ready),
    .o_wr_en     (wr_en),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .i_wr_ready  (wr_ready),
    .o_frame_ok  (frame_ok),
    .o_frame_err (frame_err),
    .o_busy      (busy)
`ifdef CMD_PARSER_RESP_EN
    ,
    .o_tx_byte   (tx_byte),
    .o_tx_start  (tx_start),
    .i_tx_busy   (tx_busy)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  logic [15:0] beats[$];
  int beat_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en && wr_ready) begin
      beats.push_back({wr_addr, wr_data});
      beat_cyc.push_back(cyc);
    end
    if (frame_ok)  ok_cnt  <= ok_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] beat_at(input int i);
    if (i < beats.size()) return beats[i];
    return 16'hxxxx;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < beat_cyc.size()) return beat_cyc[i];
    return -1000;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (n < 64) begin
      @(negedge clk);
      if (rx_ready) break;
      n++;
    end
    check(tag, 32'(n < 64), 32'd1);
  endtask

  // Four-phase receiver: hold valid until acknowledged, then keep it low
  // long enough for the acknowledge FSM to return to WAIT.
  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    wait_ready("rx_handshake");
    rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic send_good_frame();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h21);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  int qb, ok0, er0, k;
  logic found;

  initial begin
    rst_n    = 1'b0;
    rx_byte  = 8'h00;
    rx_valid = 1'b0;
    wr_ready = 1'b1;
    tick(3);
    check("reset_outputs", 32'({rx_ready, wr_en, wr_addr, wr_data, frame_ok, frame_err, busy}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    check("idle_busy", 32'(busy), 32'd0);

    // good frame: base 10, payload 11 22, checksum 21
    qb = beats.size(); ok0 = ok_cnt; er0 = err_cnt;
    send_good_frame();
    tick(6);
    check("good_beat_count", 32'(beats.size() - qb), 32'd2);
    check("good_beat0", 32'(beat_at(qb)), 32'h1011);
    check("good_beat1", 32'(beat_at(qb + 1)), 32'h1122);
    check("good_consecutive", 32'(cyc_at(qb + 1) - cyc_at(qb)), 32'd1);
    check("good_ok_pulses", 32'(ok_cnt - ok0), 32'd1);
    check("good_err_pulses", 32'(err_cnt - er0), 32'd0);
    check("good_idle", 32'({busy, wr_en}), 32'd0);

    // bad checksum 20, then recovery with a good frame
    qb = beats.size(); ok0 = ok_cnt; er0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h20);
    tick(4);
    check("badcs_beats", 32'(beats.size() - qb), 32'd0);
    check("badcs_err", 32'(err_cnt - er0), 32'd1);
    check("badcs_ok", 32'(ok_cnt - ok0), 32'd0);
    check("badcs_busy", 32'(busy), 32'd0);
    send_good_frame();
    tick(6);
    check("recover_beats", 32'(beats.size() - qb), 32'd2);
    check("recover_beat0", 32'(beat_at(qb)), 32'h1011);
    check("recover_ok", 32'(ok_cnt - ok0), 32'd1);

    // leading garbage dropped silently; FE^02^33^44 = 8B
    qb = beats.size(); ok0 = ok_cnt; er0 = err_cnt;
    send_byte(8'h00); send_byte(8'hFF);
    check("garbage_busy", 32'(busy), 32'd0);
    send_byte(8'hA5); send_byte(8'hFE); send_byte(8'h02);
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h8B);
    tick(6);
    check("garbage_err", 32'(err_cnt - er0), 32'd0);
    check("garbage_beat0", 32'(beat_at(qb)), 32'hFE33);
    check("garbage_beat1", 32'(beat_at(qb + 1)), 32'hFF44);
    check("garbage_ok", 32'(ok_cnt - ok0), 32'd1);

    // length bounds: 0 and MAX_PAYLOAD+1
    er0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00);
    tick(2);
    check("len0_err", 32'(err_cnt - er0), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    er0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h11);
    tick(2);
    check("len17_err", 32'(err_cnt - er0), 32'd1);
    check("len17_busy", 32'(busy), 32'd0);

    // inter-byte timeout measured from the strobe cycle of the 10 byte
    er0 = err_cnt;
    send_byte(8'hA5);
    rx_byte  = 8'h10;
    rx_valid = 1'b1;
    wait_ready("tmo_handshake");
    rx_valid = 1'b0;
    k = 0;
    found = 1'b0;
    while (!found && k < TMO + 10) begin
      @(negedge clk);
      k++;
      found = frame_err;
    end
    check("timeout_latency", 32'(k), 32'(TMO));
    tick(2);
    check("timeout_err", 32'(err_cnt - er0), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);

    // stalled emit with address wrap; FF^03^01^02^03 = FC
    qb = beats.size(); ok0 = ok_cnt; er0 = err_cnt;
    send_byte(8'hA5); send_byte(8'hFF); send_byte(8'h03);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    wr_ready = 1'b0;
    send_byte(8'hFC);
    rx_byte  = 8'hA5;
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("stall_beat", 32'({wr_en, wr_addr, wr_data}), 32'h1FF01);
      check("stall_no_ack", 32'(rx_ready), 32'd0);
    end
    wr_ready = 1'b1;
    wait_ready("post_emit_handshake");
    rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("stall_beat_count", 32'(beats.size() - qb), 32'd3);
    check("stall_beat0", 32'(beat_at(qb)), 32'hFF01);
    check("wrap_beat1", 32'(beat_at(qb + 1)), 32'h0002);
    check("wrap_beat2", 32'(beat_at(qb + 2)), 32'h0103);
    check("stall_ok", 32'(ok_cnt - ok0), 32'd1);
    check("stall_err", 32'(err_cnt - er0), 32'd0);
    check("pending_byte_taken", 32'(busy), 32'd1);

    // reset mid-DATA while the acknowledge is high
    ok0 = ok_cnt; er0 = err_cnt;
    send_byte(8'h10); send_byte(8'h02);
    rx_byte  = 8'h11;
    rx_valid = 1'b1;
    wait_ready("rst_handshake");
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({rx_ready, wr_en, wr_addr, wr_data, frame_ok, frame_err, busy}), 32'd0);
    rx_valid = 1'b0;
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_pulses", 32'((ok_cnt - ok0) + (err_cnt - er0)), 32'd0);

    qb = beats.size(); ok0 = ok_cnt;
    send_good_frame();
    tick(6);
    check("post_reset_frame_beat1", 32'(beat_at(qb + 1)), 32'h1122);
    check("post_reset_frame_ok", 32'(ok_cnt - ok0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART byte receiver.
- Consumes received bytes through the receiver's valid/ready four-phase handshake and parses framed write commands: sync, address, length, payload, XOR checksum.
- Buffers the payload and emits it as address/data write beats only after the checksum validates.
- Reports per-frame ok/error pulses.

Parameters:
- MAX_PAYLOAD, 16, maximum payload bytes per frame (2..64); sets buffer depth.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 2780, inter-byte timeout in clocks (about 20 bit times at 139 clocks per bit).

Ports:
- i_uart_clk  in  1  clock, same domain as the UART receiver.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rx_byte  in  8  byte from the receiver.
- i_rx_valid  in  1  receiver data-valid; held high until acknowledged.
- o_rx_ready  out  1  acknowledge to the receiver.
- o_wr_en  out  1  write beat valid.
- o_wr_addr  out  8  write address.
- o_wr_data  out  8  write data.
- i_wr_ready  in  1  sink accepts the beat when high together with o_wr_en.
- o_frame_ok  out  1  one-cycle pulse after the last beat of a good frame.
- o_frame_err  out  1  one-cycle pulse on any frame error.
- o_busy  out  1  high in any state other than HUNT.

Behaviour:
- Clock and reset: one clock, i_uart_clk. Reset is asynchronous, active-low, on i_rst_n.
- Reset values: all outputs 0; parser in HUNT; acknowledge FSM in ACK_WAIT; buffer contents don't-care.
- Acknowledge FSM (independent of the parser):
  - ACK_WAIT: if i_rx_valid is high and the parser is not in EMIT, capture i_rx_byte into the parser (one-cycle internal byte strobe), drive o_rx_ready=1 and go to ACK_HOLD.
  - ACK_HOLD: o_rx_ready=1 for exactly this one cycle, then go to ACK_DROP.
  - ACK_DROP: o_rx_ready=0; wait for i_rx_valid=0, then go to ACK_WAIT.
  - A byte is never captured twice. Bytes arriving during EMIT remain pending in the receiver until EMIT ends.
- Parser FSM (advances only on the byte strobe, except EMIT and timeout):
  - HUNT: byte==SYNC_BYTE -> ADDR. Any other byte is dropped silently with no error.
  - ADDR: latch base address; csum=byte -> LEN.
  - LEN: if 1 <= byte <= MAX_PAYLOAD, latch len, csum^=byte, idx=0 -> DATA. Otherwise pulse o_frame_err -> HUNT.
  - DATA: buf[idx]=byte, csum^=byte, idx++. When idx reaches len -> CSUM.
  - CSUM: byte==csum -> EMIT with idx=0. Mismatch: pulse o_frame_err -> HUNT.
  - EMIT:
    - Drive o_wr_en=1, o_wr_addr=base+idx (8-bit wrap, FF->00), o_wr_data=buf[idx].
    - Advance idx only when i_wr_ready is high. Outputs hold stable while stalled.
    - After the last accepted beat: o_wr_en=0, pulse o_frame_ok, go to HUNT.
- Inter-byte timeout:
  - Counter clears on every byte strobe and runs in ADDR, LEN, DATA and CSUM.
  - On reaching TIMEOUT_CYCLES-1: pulse o_frame_err -> HUNT.
  - The counter does not run in HUNT or EMIT.
- SYNC_BYTE carries no special meaning inside a frame; it is treated as ordinary data.
- Simultaneous byte strobe and timeout terminal count: the byte wins and the counter clears.
- Asserting i_rst_n low mid-frame or mid-EMIT aborts immediately with no pulses. o_rx_ready drops asynchronously.

Optional Feature:
- Macro: CMD_PARSER_RESP_EN.
- When defined:
  - Adds ports o_tx_byte (8) and o_tx_start (1), plus input i_tx_busy.
  - After o_frame_ok the parser sends 8'h06 (ACK); after o_frame_err it sends 8'h15 (NAK).
  - o_tx_start is pulsed for one cycle when i_tx_busy is low. If busy, the response is held pending, at most one deep; a newer response overwrites a pending one.
- When undefined: no extra ports and no response logic.

Decomposition:
- Shared package holds:
  - parser state encodings (HUNT, ADDR, LEN, DATA, CSUM, EMIT);
  - acknowledge state encodings;
  - ACK_BYTE 8'h06 and NAK_BYTE 8'h15;
  - the default SYNC_BYTE.
- One sub-module: uart_byte_ack, holding the four-phase acknowledge FSM and producing the byte strobe and captured byte.
- Payload buffer is a plain register array in the top module.

Test Plan:
- Bytes A5 10 02 11 22 21, i_wr_ready=1 -> beats (10,11) then (11,22) on consecutive cycles; o_frame_ok pulses once; o_frame_err stays 0.
- Same frame with checksum 20 -> no o_wr_en, one o_frame_err pulse; a following good frame is accepted.
- Bytes 00 FF A5 FE 02 33 44 (checksum FE^02^33^44=8B) then 8B -> garbage dropped without error; beats (FE,33) then (FF,44).
- LEN=00, then separately LEN=MAX_PAYLOAD+1 -> o_frame_err each time, back in HUNT; o_busy=0.
- Stop after A5 10 -> o_frame_err exactly TIMEOUT_CYCLES clocks after the 10 strobe.
- i_wr_ready low for 5 cycles during EMIT -> beat held stable; the next receiver byte stays unacknowledged until EMIT ends; reset asserted mid-DATA -> all outputs 0 immediately.
